multi_channel_processor: RTL and testbench

MULTI_CHANNEL_PROCESSOR -- requirements
Module: multi_channel_processor

---
 rtl/multi_channel_processor.sv | 107 ++++++++++
 tb/tb_multi_channel_processor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_processor.sv
// Scans enabled ADC channels, averaging 2^AVG_LOG2 samples per result; result appears the cycle after the last sample.
// Holds the result (dropping samples) until out_ready; then moves on to the next enabled channel.
module multi_channel_processor #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [3:0]        channel,
  input  logic              new_sample,
  input  logic [DATA_W-1:0] sample,
  input  logic [3:0]        sample_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_channel,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             hit;
  logic [ACC_W-1:0] sum;

  // channel never reaches NUM_CH, so out-of-range sample_channel values never match
  assign hit  = new_sample && (sample_channel == channel);
  assign sum  = acc + ACC_W'(sample);
  assign busy = (state != IDLE);

  // Next enabled index strictly after cur, wrapping; returns cur if nothing else is enabled.
  function automatic logic [3:0] next_ch(input logic [NUM_CH-1:0] en, input logic [3:0] cur);
    logic found;
    int   idx;
    next_ch = cur;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(cur) + i) % NUM_CH;
      if (!found && en[idx]) begin
        next_ch = 4'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      channel     <= '0;
      acc         <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc     <= '0;
          count   <= '0;
          channel <= '0;
          if (|ch_enable) begin
            // starting the search just past the top index yields the lowest enabled one
            channel <= next_ch(ch_enable, 4'(NUM_CH - 1));
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (hit) begin
            if (count == LAST) begin
              out_data    <= DATA_W'(sum >> AVG_LOG2);
              out_channel <= channel;
              out_valid   <= 1'b1;
              state       <= OUTPUT;
            end else begin
              acc   <= sum;
              count <= count + CNT_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            if (|ch_enable) begin
              channel <= next_ch(ch_enable, channel);
              state   <= ACCUM;
            end else begin
              channel <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_processor.sv
// Drives two instances (1-sample and 4-sample averaging) with directed and random stimulus against a behavioural model.
module tb_multi_channel_processor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] en  = '0;
  logic       ns  = 1'b0;
  logic [9:0] smp = '0;
  logic [3:0] sch = '0;
  logic       rdy = 1'b0;

  logic [3:0] ch_o[2];
  logic [3:0] och_o[2];
  logic [9:0] dat_o[2];
  logic       vld_o[2];
  logic       busy_o[2];

  int n_vec = 0;
  int n_err = 0;

  // model state per instance: index 0 averages 1 sample, index 1 averages 4
  int NS[2] = '{1, 4};
  bit m_act[2];
  bit m_pend[2];
  int m_ch[2];
  int m_och[2];
  int m_res[2];
  int m_sum[2];
  int m_cnt[2];

  always #5 clk = ~clk;

  multi_channel_processor #(.NUM_CH(4), .DATA_W(10), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .ch_enable(en), .channel(ch_o[0]), .new_sample(ns),
    .sample(smp), .sample_channel(sch), .out_valid(vld_o[0]), .out_ready(rdy),
    .out_data(dat_o[0]), .out_channel(och_o[0]), .busy(busy_o[0]));

  multi_channel_processor #(.NUM_CH(4), .DATA_W(10), .AVG_LOG2(2)) dut4 (
    .clk(clk), .rst(rst), .ch_enable(en), .channel(ch_o[1]), .new_sample(ns),
    .sample(smp), .sample_channel(sch), .out_valid(vld_o[1]), .out_ready(rdy),
    .out_data(dat_o[1]), .out_channel(och_o[1]), .busy(busy_o[1]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int lowest_en(input logic [3:0] e);
    for (int i = 0; i < 4; i++) if (e[i]) return i;
    return 0;
  endfunction

  function automatic int after_en(input logic [3:0] e, input int cur);
    for (int i = cur + 1; i < 4; i++) if (e[i]) return i;
    return lowest_en(e);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_pend[k] = 0; m_ch[k] = 0; m_och[k] = 0;
      m_res[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      if (!m_act[k]) begin
        if (en != 0) begin
          m_act[k] = 1;
          m_ch[k]  = lowest_en(en);
        end
      end else if (m_pend[k]) begin
        if (rdy) begin
          m_pend[k] = 0;
          if (en == 0) begin
            m_act[k] = 0;
            m_ch[k]  = 0;
          end else begin
            m_ch[k] = after_en(en, m_ch[k]);
          end
        end
      end else if (ns && int'(sch) == m_ch[k]) begin
        m_sum[k] += int'(smp);
        m_cnt[k]++;
        if (m_cnt[k] == NS[k]) begin
          m_res[k]  = m_sum[k] / NS[k];
          m_och[k]  = m_ch[k];
          m_pend[k] = 1;
          m_sum[k]  = 0;
          m_cnt[k]  = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("channel[%0d]", k), 32'(ch_o[k]), m_ch[k]);
      check($sformatf("out_valid[%0d]", k), 32'(vld_o[k]), 32'(m_pend[k]));
      check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_act[k]));
      check($sformatf("out_data[%0d]", k), 32'(dat_o[k]), m_res[k]);
      check($sformatf("out_channel[%0d]", k), 32'(och_o[k]), m_och[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic cyc(input logic [3:0] e, input logic s, input int v, input int c, input logic r);
    en = e; ns = s; smp = 10'(v); sch = 4'(c); rdy = r;
    step();
  endtask

  // asserted wherever the caller stands (mid-cycle), released after the next falling edge
  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // four-sample average with two channels enabled
    apply_reset();
    cyc(4'b0101, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0101, 1, 100 + i, 0, 0);
    check("avg_valid", 32'(vld_o[1]), 1);
    check("avg_data", 32'(dat_o[1]), 101);
    check("avg_chan", 32'(och_o[1]), 0);
    cyc(4'b0101, 0, 0, 0, 1);
    check("avg_next_chan", 32'(ch_o[1]), 2);

    // single-sample pass-through on a lone channel
    apply_reset();
    cyc(4'b1000, 0, 0, 0, 0);
    cyc(4'b1000, 1, 1023, 3, 0);
    check("pass_data", 32'(dat_o[0]), 1023);
    check("pass_valid", 32'(vld_o[0]), 1);
    cyc(4'b1000, 0, 0, 0, 1);
    check("pass_stay", 32'(ch_o[0]), 3);

    // foreign-channel strobes interleaved, then held output with strobes dropped
    apply_reset();
    cyc(4'b0011, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0011, 1, 500, 1, 0);
      cyc(4'b0011, 1, 8, 0, 0);
    end
    check("ilv_data", 32'(dat_o[1]), 8);
    for (int i = 0; i < 10; i++) cyc(4'b0011, 1, $urandom_range(0, 1023), 0, 0);
    check("hold_data", 32'(dat_o[1]), 8);
    check("hold_valid", 32'(vld_o[1]), 1);
    cyc(4'b0011, 0, 0, 0, 1);
    check("hold_next", 32'(ch_o[1]), 1);
    for (int i = 0; i < 4; i++) cyc(4'b0011, 1, 20, 1, 0);
    check("fresh_data", 32'(dat_o[1]), 20);
    check("fresh_chan", 32'(och_o[1]), 1);

    // async reset mid-accumulation discards the partial sum
    apply_reset();
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(4'b0001, 1, 77, 0, 0);
    cyc(4'b0001, 1, 77, 0, 0);
    #2;
    apply_reset();
    check("rst_busy", 32'(busy_o[1]), 0);
    cyc(4'b0001, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1, 40, 0, 0);
    check("rst_data", 32'(dat_o[1]), 40);

    // enable mask cleared mid-accumulation: result still delivered, then idle
    apply_reset();
    cyc(4'b0011, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1, 7, 0, 0);
    check("dis_data", 32'(dat_o[1]), 7);
    cyc(4'b0000, 0, 0, 0, 1);
    check("dis_busy", 32'(busy_o[1]), 0);
    check("dis_chan", 32'(ch_o[1]), 0);

    // randomized traffic
    apply_reset();
    en = 4'($urandom_range(1, 15));
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] e;
      int         c;
      e = en;
      if ($urandom_range(0, 99) < 4) e = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0, 1:    c = m_ch[1];
        2:       c = m_ch[0];
        default: c = $urandom_range(0, 7);
      endcase
      cyc(e, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), c, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #($urandom_range(1, 3));
        apply_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
